// File: rtl/boxcar_filter_mc.sv
// Time-multiplexed multi-channel boxcar average over a runtime power-of-two window.
// Latency CHANNELS+2 cycles from strobe to dout_valid (+DEPTH on window change); strobes while busy are dropped and flagged.
module boxcar_filter_mc #(
  parameter int WIDTH      = 12,
  parameter int CHANNELS   = 4,
  parameter int DEPTH_LOG2 = 4,
  parameter int LW         = $clog2(DEPTH_LOG2 + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_stb,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [LW-1:0]             len_log2,
  input  logic                      bypass,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW    = WIDTH + DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, FLUSH, PROC, DONE} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0]          hist [CHANNELS][DEPTH];
  logic [AW-1:0]             acc [CHANNELS];
  logic [AW-1:0]             shifted [CHANNELS];
  logic [DEPTH_LOG2-1:0]     wr_ptr, fl_addr, rd_addr;
  logic [DEPTH_LOG2:0]       win;
  logic [LW-1:0]             cur_len, new_len;
  logic [CHANNELS*WIDTH-1:0] din_q;
  logic                      bypass_q;
  logic [CW-1:0]             ch_idx;
  logic [WIDTH-1:0]          cur_din, old;
  logic                      last_ch;

  assign new_len = (len_log2 > LW'(DEPTH_LOG2)) ? LW'(DEPTH_LOG2) : len_log2;
  // At L = DEPTH the window wraps to wr_ptr itself; the register array returns the pre-write value.
  assign win     = (DEPTH_LOG2 + 1)'(1) << cur_len;
  assign rd_addr = wr_ptr - win[DEPTH_LOG2-1:0];
  assign cur_din = din_q[ch_idx*WIDTH +: WIDTH];
  assign old     = hist[ch_idx][rd_addr];
  assign last_ch = (ch_idx == CW'(CHANNELS - 1));
  assign busy    = (state != IDLE);

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) shifted[c] = acc[c] >> cur_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sample_stb) state_n = (new_len != cur_len) ? FLUSH : PROC;
      FLUSH:   if (fl_addr == '1) state_n = PROC;
      PROC:    if (last_ch) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      wr_ptr     <= '0;
      fl_addr    <= '0;
      ch_idx     <= '0;
      cur_len    <= '0;
      din_q      <= '0;
      bypass_q   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c] <= '0;
        for (int d = 0; d < DEPTH; d++) hist[c][d] <= '0;
      end
    end else begin
      dout_valid <= 1'b0;
      if (sample_stb && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_stb) begin
          din_q    <= din;
          bypass_q <= bypass;
          cur_len  <= new_len;
          ch_idx   <= '0;
          fl_addr  <= '0;
        end
        FLUSH: begin
          for (int c = 0; c < CHANNELS; c++) hist[c][fl_addr] <= '0;
          if (fl_addr == '0) begin
            wr_ptr <= '0;
            for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
          end
          fl_addr <= fl_addr + DEPTH_LOG2'(1);
        end
        PROC: begin
          acc[ch_idx]          <= acc[ch_idx] + AW'(cur_din) - AW'(old);
          hist[ch_idx][wr_ptr] <= cur_din;
          if (last_ch) begin
            ch_idx <= '0;
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
          end else begin
            ch_idx <= ch_idx + CW'(1);
          end
        end
        DONE: begin
          for (int c = 0; c < CHANNELS; c++)
            dout[c*WIDTH +: WIDTH] <= bypass_q ? din_q[c*WIDTH +: WIDTH] : shifted[c][WIDTH-1:0];
          dout_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/boxcar_filter_mc.md
Name: boxcar_filter_mc

Overview:
Multi-channel, time-multiplexed moving-average (boxcar) low-pass filter for the audio path. It replaces the fixed 16-tap, single-voice delay-line integrator with a parametrised block that has:
- a circular-buffer history per channel;
- a runtime-selectable power-of-two window with automatic flush on change;
- normalised output and a bypass mode.

It sits between the voice generators (fed by the 48 kHz sample strobe) and the mixer/PDM stage.

Parameters:
- WIDTH, 12: unsigned sample width per channel.
- CHANNELS, 4: number of independent channels.
- DEPTH_LOG2, 4: log2 of history depth per channel (DEPTH = 2^DEPTH_LOG2 = 16).
- LW, $clog2(DEPTH_LOG2+1): width of len_log2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- sample_stb  in  1  one-cycle pulse per sample period; din and len_log2 sampled on it
- din  in  CHANNELS*WIDTH  unsigned samples, channel c at bits [c*WIDTH +: WIDTH]
- len_log2  in  LW  window L = 2^len_log2; values > DEPTH_LOG2 clamp to DEPTH_LOG2
- bypass  in  1  1: dout = latched din; filter state still updates
- dout  out  CHANNELS*WIDTH  filtered samples, same packing as din
- dout_valid  out  1  one-cycle pulse when dout updates
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; set when sample_stb arrives while busy

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all of the following:
  - dout=0, dout_valid=0, busy=0, overrun=0;
  - all accumulators, all history entries, wr_ptr, ch_idx;
  - cur_len=0; state=IDLE.
- Reset mid-operation aborts immediately. Partial results are discarded and no dout_valid is issued.
- Internal state:
  - hist[c][0..DEPTH-1], WIDTH bits each;
  - acc[c], WIDTH+DEPTH_LOG2 bits, which can never overflow;
  - wr_ptr, DEPTH_LOG2 bits, wraps modulo DEPTH;
  - cur_len, LW bits;
  - din_q, bypass_q.
- States: IDLE, FLUSH, PROC, DONE.
- IDLE, on sample_stb:
  - latch din to din_q, bypass to bypass_q, and clamp(len_log2) to new_len;
  - if new_len != cur_len: cur_len <= new_len, go to FLUSH;
  - otherwise go to PROC with ch_idx=0.
- FLUSH:
  - clears one history address per cycle for all channels in parallel, addresses 0..DEPTH-1 over DEPTH cycles;
  - accumulators and wr_ptr are zeroed in the first FLUSH cycle;
  - then goes to PROC with ch_idx=0;
  - dout holds its old value during FLUSH.
- PROC, one channel per cycle, c = ch_idx:
  - old = hist[c][(wr_ptr - 2^cur_len) mod DEPTH];
  - acc[c] <= acc[c] + din_q[c] - old;
  - hist[c][wr_ptr] <= din_q[c].
- Read-before-write: when L = DEPTH, the read address equals wr_ptr. The read must return the pre-write (oldest) value.
- After ch_idx = CHANNELS-1: wr_ptr <= wr_ptr+1, go to DONE.
- DONE (one cycle), for every c:
  - dout[c] <= bypass_q ? din_q[c] : (acc[c] >> cur_len)[WIDTH-1:0], which is a truncating average;
  - dout_valid=1;
  - return to IDLE.
- Latency, with sample_stb at edge T:
  - no flush: dout_valid is high in the cycle after edge T+CHANNELS+1;
  - with flush: add DEPTH cycles.
- busy is high from the cycle after the accepting sample_stb through the DONE cycle.
- A sample_stb while busy (including the DONE cycle) is dropped and sets overrun. overrun clears only on reset.
- Startup/flush transient: history reads as zero, so output ramps over the first L samples (k*x/L after k samples of constant x).
- len_log2 changes between strobes are ignored. Only the value at an accepted strobe matters.

Test Plan:
- Reset, then no stimulus for 100 cycles -> dout=0, dout_valid=0, busy=0, overrun=0 throughout.
- len_log2=2, all channels din=100, 6 strobes 64 cycles apart:
  - first strobe flushes, so dout_valid arrives 16+4+1 cycles after the strobe;
  - outputs are 25, 50, 75, 100, 100, 100.
- len_log2=4, ch0 impulse 4095 followed by zeros, ch1 constant 16, 40 strobes:
  - ch0 = 255 for exactly 16 outputs, then 0 (covers wr_ptr wrap and read-before-write at L=DEPTH);
  - ch1 ramps to 16 and holds.
- Steady state at len_log2=3 with output 100; then strobe with len_log2=1 and din=8 -> FLUSH occurs; outputs 4, 8, 8.
- Strobe at T, second strobe at T+2 -> second strobe dropped, overrun=1 and stays 1, exactly one dout_valid.
- bypass=1 with varying din -> dout equals the strobed din on each dout_valid. Deassert bypass after 8 samples at len_log2=3 -> dout equals the true 8-sample average of the last 8 inputs (state kept updating during bypass).
